// File: rtl/multi_port_reg_file_pkg.sv
// Shared definitions for the multi-port register file: register count, zero-register
// index and the busy-scoreboard update priority.
package multi_port_reg_file_pkg;

   localparam int unsigned ZERO_REG_ADDR = 0;

   typedef enum logic [1:0] {
      BUSY_HOLD,
      BUSY_SET,
      BUSY_CLEAR,
      BUSY_FLUSH
   } busy_op_e;

   function automatic int unsigned reg_count(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

   // Flush beats reserve, reserve beats a same-edge write-back.
   function automatic busy_op_e busy_op(input logic flush,
                                        input logic reserve_hit,
                                        input logic write_hit);
      if (flush)       return BUSY_FLUSH;
      if (reserve_hit) return BUSY_SET;
      if (write_hit)   return BUSY_CLEAR;
      return BUSY_HOLD;
   endfunction

endpackage

// File: rtl/multi_port_reg_file_if.sv
// Decode/write-back side bus of the register file: packed read, write and reserve ports.
interface multi_port_reg_file_if #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 5,
   parameter int unsigned READ_PORTS  = 2,
   parameter int unsigned WRITE_PORTS = 1
);
   logic [READ_PORTS-1:0]              read_en;
   logic [READ_PORTS*ADDR_WIDTH-1:0]   read_addr;
   logic [READ_PORTS*DATA_WIDTH-1:0]   read_data;
   logic [READ_PORTS-1:0]              read_busy;
   logic [WRITE_PORTS-1:0]             write_en;
   logic [WRITE_PORTS*ADDR_WIDTH-1:0]  write_addr;
   logic [WRITE_PORTS*DATA_WIDTH-1:0]  write_data;
   logic                               reserve_en;
   logic [ADDR_WIDTH-1:0]              reserve_addr;
   logic                               flush;

   modport master (
      output read_en, read_addr, write_en, write_addr, write_data,
             reserve_en, reserve_addr, flush,
      input  read_data, read_busy
   );

   modport slave (
      input  read_en, read_addr, write_en, write_addr, write_data,
             reserve_en, reserve_addr, flush,
      output read_data, read_busy
   );
endinterface

// File: rtl/multi_port_reg_file_read_port.sv
// One read port: storage mux, same-cycle write bypass and busy lookup.
module reg_file_read_port
   import multi_port_reg_file_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH  = 32,
   parameter  int unsigned ADDR_WIDTH  = 5,
   parameter  int unsigned WRITE_PORTS = 1,
   parameter  int unsigned ZERO_REG    = 1,
   parameter  int unsigned BYPASS      = 1,
   localparam int unsigned REG_COUNT   = reg_count(ADDR_WIDTH)
) (
   input  logic                  rst,
   input  logic                  en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] regs [REG_COUNT],
   input  logic [REG_COUNT-1:0]  busy,
   input  logic [WRITE_PORTS-1:0] wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr [WRITE_PORTS],
   input  logic [DATA_WIDTH-1:0] wr_data [WRITE_PORTS],
   output logic [DATA_WIDTH-1:0] data,
   output logic                  busy_out
);
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG_ADDR);
   localparam bit ZERO_ON   = (ZERO_REG != 0);
   localparam bit BYPASS_ON = (BYPASS != 0);

   logic                  hit;
   logic [DATA_WIDTH-1:0] fwd;

   // Ascending scan so the highest matching write port ends up in fwd.
   always_comb begin
      hit = 1'b0;
      fwd = '0;
      for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
         if (wr_en[k] && wr_addr[k] == addr) begin
            hit = 1'b1;
            fwd = wr_data[k];
         end
      end
   end

   always_comb begin
      data     = '0;
      busy_out = 1'b0;
      if (!rst && en && !(ZERO_ON && addr == ZERO_IDX)) begin
         data     = (BYPASS_ON && hit) ? fwd : regs[addr];
         busy_out = busy[addr] && !(BYPASS_ON && hit);
      end
   end
endmodule

// File: rtl/multi_port_reg_file.sv
// Parametrised N-read/M-write register file with write bypass and a per-register
// busy scoreboard for long-latency producers.
module multi_port_reg_file
   import multi_port_reg_file_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 5,
   parameter int unsigned READ_PORTS  = 2,
   parameter int unsigned WRITE_PORTS = 1,
   parameter int unsigned ZERO_REG    = 1,
   parameter int unsigned BYPASS      = 1
) (
   input logic                 clk,
   input logic                 rst,
   multi_port_reg_file_if.slave bus
);
   localparam int unsigned REG_COUNT = reg_count(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG_ADDR);
   localparam bit ZERO_ON = (ZERO_REG != 0);

   logic [DATA_WIDTH-1:0] regs [REG_COUNT];
   logic [REG_COUNT-1:0]  busy;
   logic [REG_COUNT-1:0]  busy_next;
   logic [REG_COUNT-1:0]  write_hit;

   logic [ADDR_WIDTH-1:0] wr_addr [WRITE_PORTS];
   logic [DATA_WIDTH-1:0] wr_data [WRITE_PORTS];
   logic [DATA_WIDTH-1:0] rd_data [READ_PORTS];
   logic                  rd_busy [READ_PORTS];

   always_comb begin
      for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
         wr_addr[k] = bus.write_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
         wr_data[k] = bus.write_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Later loop iterations override earlier ones, so the highest write port wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < REG_COUNT; r++) begin
            regs[r] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
            if (bus.write_en[k] && !(ZERO_ON && wr_addr[k] == ZERO_IDX)) begin
               regs[wr_addr[k]] <= wr_data[k];
            end
         end
      end
   end

   always_comb begin
      write_hit = '0;
      for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
         if (bus.write_en[k]) begin
            write_hit[wr_addr[k]] = 1'b1;
         end
      end
   end

   always_comb begin
      busy_next = busy;
      for (int unsigned r = 0; r < REG_COUNT; r++) begin
         case (busy_op(bus.flush,
                       bus.reserve_en && (bus.reserve_addr == ADDR_WIDTH'(r)),
                       write_hit[r]))
            BUSY_FLUSH: busy_next[r] = 1'b0;
            BUSY_SET:   busy_next[r] = 1'b1;
            BUSY_CLEAR: busy_next[r] = 1'b0;
            BUSY_HOLD:  busy_next[r] = busy[r];
         endcase
      end
      if (ZERO_ON) begin
         busy_next[ZERO_REG_ADDR] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   for (genvar i = 0; i < READ_PORTS; i++) begin : g_read
      reg_file_read_port #(
         .DATA_WIDTH  (DATA_WIDTH),
         .ADDR_WIDTH  (ADDR_WIDTH),
         .WRITE_PORTS (WRITE_PORTS),
         .ZERO_REG    (ZERO_REG),
         .BYPASS      (BYPASS)
      ) u_read_port (
         .rst      (rst),
         .en       (bus.read_en[i]),
         .addr     (bus.read_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
         .regs     (regs),
         .busy     (busy),
         .wr_en    (bus.write_en),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .data     (rd_data[i]),
         .busy_out (rd_busy[i])
      );
   end

   always_comb begin
      bus.read_data = '0;
      bus.read_busy = '0;
      for (int unsigned i = 0; i < READ_PORTS; i++) begin
         bus.read_data[i*DATA_WIDTH +: DATA_WIDTH] = rd_data[i];
         bus.read_busy[i]                          = rd_busy[i];
      end
   end
endmodule

// File: tb/tb_multi_port_reg_file.sv
// Directed bench: a 2R2W bypassing file and a 2R1W non-bypassing file driven in lockstep.
module tb_multi_port_reg_file;
   localparam int DW = 32;
   localparam int AW = 5;

   typedef enum int {S_D0, S_D1, S_B0, S_B1, S_N0, S_N1, S_NB0, S_NB1} sel_e;
   typedef struct {
      sel_e        sel;
      logic [31:0] val;
      string       tag;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   multi_port_reg_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(2), .WRITE_PORTS(2)) bus ();
   multi_port_reg_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(2), .WRITE_PORTS(1)) bus_nb ();

   multi_port_reg_file #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(2), .WRITE_PORTS(2), .ZERO_REG(1), .BYPASS(1)
   ) dut (.clk(clk), .rst(rst), .bus(bus));

   multi_port_reg_file #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(2), .WRITE_PORTS(1), .ZERO_REG(1), .BYPASS(0)
   ) dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic idle();
      bus.read_en = '0;      bus.read_addr = '0;
      bus.write_en = '0;     bus.write_addr = '0;   bus.write_data = '0;
      bus.reserve_en = 1'b0; bus.reserve_addr = '0; bus.flush = 1'b0;
      bus_nb.read_en = '0;      bus_nb.read_addr = '0;
      bus_nb.write_en = '0;     bus_nb.write_addr = '0;   bus_nb.write_data = '0;
      bus_nb.reserve_en = 1'b0; bus_nb.reserve_addr = '0; bus_nb.flush = 1'b0;
   endtask

   task automatic set_rd(input int p, input int a);
      bus.read_en[p] = 1'b1;    bus.read_addr[p*AW +: AW] = AW'(a);
      bus_nb.read_en[p] = 1'b1; bus_nb.read_addr[p*AW +: AW] = AW'(a);
   endtask

   task automatic set_wr(input int k, input int a, input logic [31:0] d);
      bus.write_en[k] = 1'b1;
      bus.write_addr[k*AW +: AW] = AW'(a);
      bus.write_data[k*DW +: DW] = d;
      if (k == 0) begin
         bus_nb.write_en[0] = 1'b1;
         bus_nb.write_addr[AW-1:0] = AW'(a);
         bus_nb.write_data[DW-1:0] = d;
      end
   endtask

   task automatic reserve(input int a);
      bus.reserve_en = 1'b1;    bus.reserve_addr = AW'(a);
      bus_nb.reserve_en = 1'b1; bus_nb.reserve_addr = AW'(a);
   endtask

   task automatic exp(input sel_e s, input logic [31:0] v, input string tag);
      exp_t e;
      e.sel = s; e.val = v; e.tag = tag;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] observe(input sel_e s);
      case (s)
         S_D0:    return bus.read_data[31:0];
         S_D1:    return bus.read_data[63:32];
         S_B0:    return {31'b0, bus.read_busy[0]};
         S_B1:    return {31'b0, bus.read_busy[1]};
         S_N0:    return bus_nb.read_data[31:0];
         S_N1:    return bus_nb.read_data[63:32];
         S_NB0:   return {31'b0, bus_nb.read_busy[0]};
         default: return {31'b0, bus_nb.read_busy[1]};
      endcase
   endfunction

   task automatic check();
      exp_t        e;
      logic [31:0] obs;
      #1;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sel);
         n_checks++;
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      // Outputs held at zero during reset even with a bypassing write presented.
      set_rd(0, 5); set_rd(1, 3); set_wr(0, 3, 32'hDEADBEEF); reserve(3);
      exp(S_D0, 0, "rst_d0"); exp(S_D1, 0, "rst_d1"); exp(S_B1, 0, "rst_b1"); exp(S_N1, 0, "rst_nb_d1");
      check();

      @(negedge clk); rst = 1'b0; idle(); set_wr(0, 5, 32'h1234);
      @(negedge clk); idle(); set_rd(0, 5);
      exp(S_D0, 32'h1234, "preload_r5"); exp(S_N0, 32'h1234, "preload_r5_nb");
      check();
      #1 rst = 1'b1;
      exp(S_D0, 0, "rst_mid_d0"); exp(S_B0, 0, "rst_mid_b0"); exp(S_N0, 0, "rst_mid_nb_d0");
      check();
      @(negedge clk); rst = 1'b0;
      exp(S_D0, 0, "post_rst_r5"); exp(S_B0, 0, "post_rst_b0"); exp(S_N0, 0, "post_rst_nb_r5");
      check();

      // Bypass
      @(negedge clk); idle(); set_wr(0, 3, 32'hDEADBEEF); set_rd(0, 3); set_rd(1, 3);
      exp(S_D0, 32'hDEADBEEF, "byp_d0"); exp(S_D1, 32'hDEADBEEF, "byp_d1");
      exp(S_N0, 0, "nobyp_old_d0"); exp(S_N1, 0, "nobyp_old_d1");
      check();
      @(negedge clk); idle(); set_rd(0, 3); set_rd(1, 3);
      exp(S_D0, 32'hDEADBEEF, "byp_next_d0"); exp(S_N0, 32'hDEADBEEF, "nobyp_new_d0");
      exp(S_N1, 32'hDEADBEEF, "nobyp_new_d1");
      check();

      // Zero register
      @(negedge clk); idle(); set_wr(0, 0, 32'hFFFFFFFF); reserve(0); set_rd(0, 0); set_rd(1, 0);
      exp(S_D0, 0, "zero_d0"); exp(S_D1, 0, "zero_d1"); exp(S_B0, 0, "zero_b0"); exp(S_B1, 0, "zero_b1");
      exp(S_N0, 0, "zero_nb_d0");
      check();
      @(negedge clk); idle(); set_rd(0, 0); set_rd(1, 0);
      exp(S_D0, 0, "zero_next_d0"); exp(S_B0, 0, "zero_next_b0"); exp(S_B1, 0, "zero_next_b1");
      exp(S_NB0, 0, "zero_next_nb_b0");
      check();

      // Write collision: higher port wins
      @(negedge clk); idle(); set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); set_rd(0, 7);
      exp(S_D0, 32'h22, "coll_byp_d0");
      check();
      @(negedge clk); idle(); set_rd(0, 7); set_rd(1, 7);
      exp(S_D0, 32'h22, "coll_next_d0"); exp(S_D1, 32'h22, "coll_next_d1"); exp(S_N0, 32'h11, "coll_nb_d0");
      check();

      // Scoreboard
      @(negedge clk); idle(); reserve(9); set_rd(0, 9);
      exp(S_B0, 0, "rsv_same_b0"); exp(S_NB0, 0, "rsv_same_nb_b0");
      check();
      @(negedge clk); idle(); set_rd(0, 9); set_rd(1, 9);
      exp(S_B0, 1, "rsv_next_b0"); exp(S_B1, 1, "rsv_next_b1"); exp(S_D0, 0, "rsv_next_d0");
      exp(S_NB0, 1, "rsv_next_nb_b0");
      check();
      @(negedge clk); idle(); set_wr(0, 9, 32'h55); set_rd(0, 9);
      exp(S_B0, 0, "wb_b0"); exp(S_D0, 32'h55, "wb_d0"); exp(S_NB0, 1, "wb_nb_b0"); exp(S_N0, 0, "wb_nb_d0");
      check();
      @(negedge clk); idle(); set_rd(0, 9);
      exp(S_B0, 0, "wb_next_b0"); exp(S_D0, 32'h55, "wb_next_d0");
      exp(S_NB0, 0, "wb_next_nb_b0"); exp(S_N0, 32'h55, "wb_next_nb_d0");
      check();
      @(negedge clk); idle(); reserve(9); set_wr(1, 9, 32'h66); set_rd(0, 9);
      exp(S_D0, 32'h66, "rsvwb_d0"); exp(S_B0, 0, "rsvwb_b0");
      check();
      @(negedge clk); idle(); set_rd(0, 9);
      exp(S_B0, 1, "rsvwb_next_b0"); exp(S_D0, 32'h66, "rsvwb_next_d0"); exp(S_NB0, 1, "rsv_nb_b0");
      check();
      @(negedge clk); idle(); set_wr(1, 9, 32'h77); set_rd(0, 9);
      exp(S_B0, 0, "wb1_b0"); exp(S_D0, 32'h77, "wb1_d0");
      check();
      @(negedge clk); idle(); set_rd(0, 9);
      exp(S_B0, 0, "wb1_next_b0"); exp(S_D0, 32'h77, "wb1_next_d0");
      check();

      // Flush
      @(negedge clk); idle(); reserve(4);
      @(negedge clk); idle(); reserve(6); set_rd(0, 4);
      bus.read_addr[AW +: AW] = AW'(4);
      exp(S_B0, 1, "r4_busy_b0"); exp(S_D1, 0, "rden0_d1"); exp(S_B1, 0, "rden0_b1");
      check();
      @(negedge clk); idle(); bus.flush = 1'b1; bus_nb.flush = 1'b1; reserve(8); set_rd(0, 4); set_rd(1, 6);
      exp(S_B0, 1, "pre_flush_b0"); exp(S_B1, 1, "pre_flush_b1"); exp(S_NB0, 1, "pre_flush_nb_b0");
      check();
      @(negedge clk); idle(); set_rd(0, 4); set_rd(1, 6);
      exp(S_B0, 0, "flush_r4"); exp(S_B1, 0, "flush_r6"); exp(S_NB0, 0, "flush_nb_r4"); exp(S_NB1, 0, "flush_nb_r6");
      check();
      @(negedge clk); idle(); set_rd(0, 8); set_rd(1, 9);
      exp(S_B0, 0, "flush_r8"); exp(S_B1, 0, "flush_r9"); exp(S_NB0, 0, "flush_nb_r8"); exp(S_NB1, 0, "flush_nb_r9");
      check();

      @(negedge clk); idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
